// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo channel datapath: the pulse-width type,
// default channel count and width limits (shared with servo_pwm), the state
// encoding of the slew limiter, and the single-channel slew step helper.
// No ports (package).
// -----------------------------------------------------------------------------
package servo_pkg;

  typedef logic [15:0] width_t;

  localparam int SERVO_NUM_CH    = 5;
  localparam int SERVO_MIN_US    = 1000;
  localparam int SERVO_MAX_US    = 2000;
  localparam int SERVO_CENTER_US = 1500;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } ramp_state_e;

  // Moves cur toward tgt by at most step. Work in 17 bits and compare the
  // remaining gap against the step, so neither direction can wrap.
  function automatic width_t slew_step(input width_t cur,
                                       input width_t tgt,
                                       input width_t step);
    logic [16:0] cur_x;
    logic [16:0] tgt_x;
    logic [16:0] step_x;
    logic [16:0] nxt_x;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    step_x = {1'b0, step};
    nxt_x  = cur_x;
    if (cur_x < tgt_x) begin
      nxt_x = ((tgt_x - cur_x) <= step_x) ? tgt_x : (cur_x + step_x);
    end else if (cur_x > tgt_x) begin
      nxt_x = ((cur_x - tgt_x) <= step_x) ? tgt_x : (cur_x - step_x);
    end
    return nxt_x[15:0];
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// -----------------------------------------------------------------------------
// servo_tick_gen
// Free-running divider that paces the servo update stages. The count runs
// 0..TICK_DIV-1 and wraps; tick is high for the one cycle where the count is
// at its last value, so the first tick after reset lands on cycle TICK_DIV-1.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   out  one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module servo_tick_gen #(
  parameter int TICK_DIV = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_slew_ramp.sv
// -----------------------------------------------------------------------------
// servo_slew_ramp
// Per-channel slew-rate limiter feeding the servo_pwm generators. Targets
// arrive over a valid/ready handshake and are clamped to [MIN_US, MAX_US].
// On every tick the block walks the channels one per cycle, moving each
// current width toward its target by at most STEP_US.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   cmd_valid     in   command present
//   cmd_ready     out  command can be accepted (low while a pass runs)
//   cmd_ch        in   target channel index
//   cmd_width_us  in   requested width in us
//   cmd_err       out  one-cycle pulse after accepting an out-of-range channel
//   width_us      out  current width per channel, to servo_pwm
//   at_target     out  per channel: current width equals target
//   busy          out  any channel still moving
// -----------------------------------------------------------------------------
module servo_slew_ramp
  import servo_pkg::*;
#(
  parameter int NUM_CH    = SERVO_NUM_CH,
  parameter int TICK_DIV  = 250_000,
  parameter int STEP_US   = 10,
  parameter int MIN_US    = SERVO_MIN_US,
  parameter int MAX_US    = SERVO_MAX_US,
  parameter int CENTER_US = SERVO_CENTER_US
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  width_t            cmd_width_us,
  output logic              cmd_err,
  output width_t            width_us [NUM_CH],
  output logic [NUM_CH-1:0] at_target,
  output logic              busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam width_t STEP_W   = width_t'(STEP_US);
  localparam width_t MIN_W    = width_t'(MIN_US);
  localparam width_t MAX_W    = width_t'(MAX_US);
  localparam width_t CENTER_W = width_t'(CENTER_US);

  // A full pass must finish, with an idle cycle to spare, before the next tick.
  if (TICK_DIV < NUM_CH + 2) begin : g_bad_tick_div
    $error("servo_slew_ramp: TICK_DIV must be at least NUM_CH + 2");
  end

  ramp_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  width_t            cur_q [NUM_CH];
  width_t            cur_d [NUM_CH];
  width_t            tgt_q [NUM_CH];
  width_t            tgt_d [NUM_CH];
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] at_q, at_d;
  logic              busy_q, busy_d;

  logic   tick;
  logic   accept;
  logic   bad_ch;
  width_t clamped;

  servo_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign accept = cmd_valid && ready_q;
  assign bad_ch = int'(cmd_ch) >= NUM_CH;

  always_comb begin
    clamped = cmd_width_us;
    if (cmd_width_us < MIN_W) begin
      clamped = MIN_W;
    end else if (cmd_width_us > MAX_W) begin
      clamped = MAX_W;
    end
  end

  // cmd_ready is registered from the next state so it drops in the same
  // edge that starts a pass; a command seen in the tick cycle is still taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Accepts only happen in IDLE, so a target write and a width update for
  // the same channel never coincide.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      if (accept && !bad_ch && (int'(cmd_ch) == i)) begin
        tgt_d[i] = clamped;
      end
      if ((state_q == UPDATE) && (int'(idx_q) == i)) begin
        cur_d[i] = slew_step(cur_q[i], tgt_q[i], STEP_W);
      end
      at_d[i] = (cur_q[i] == tgt_q[i]);
    end
    busy_d = ~&at_d;
    err_d  = accept && bad_ch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      at_q    <= '1;
      busy_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i] <= CENTER_W;
        tgt_q[i] <= CENTER_W;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      at_q    <= at_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i] <= cur_d[i];
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign width_us  = cur_q;
  assign at_target = at_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_servo_slew_ramp.sv
// -----------------------------------------------------------------------------
// tb_servo_slew_ramp
// Directed bench for servo_slew_ramp with TICK_DIV = 16. Inputs are driven
// and outputs sampled on the falling edge; every expected value is a
// hand-computed constant.
// -----------------------------------------------------------------------------
module tb_servo_slew_ramp;

  localparam int NCH = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_ch = '0;
  logic [15:0] cmd_width_us = '0;
  logic        cmd_ready;
  logic        cmd_err;
  logic [15:0] width_us [NCH];
  logic [NCH-1:0] at_target;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servo_slew_ramp #(
    .NUM_CH    (NCH),
    .TICK_DIV  (16),
    .STEP_US   (10),
    .MIN_US    (1000),
    .MAX_US    (2000),
    .CENTER_US (1500)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ch       (cmd_ch),
    .cmd_width_us (cmd_width_us),
    .cmd_err      (cmd_err),
    .width_us     (width_us),
    .at_target    (at_target),
    .busy         (busy)
  );

  // Presents one command for a single cycle; caller ensures cmd_ready is high.
  task automatic send_cmd(input logic [2:0] ch, input logic [15:0] w);
    cmd_valid    = 1'b1;
    cmd_ch       = ch;
    cmd_width_us = w;
    @(negedge clk);
    cmd_valid    = 1'b0;
  endtask

  // From IDLE, waits for the next update pass to start and finish, then one
  // more cycle so at_target/busy reflect the new widths.
  task automatic wait_pass();
    int n;
    n = 0;
    while (cmd_ready !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pass_start: cmd_ready=%b required 0 within 40 cycles", cmd_ready);
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pass_end: cmd_ready=%b required 1 within 10 cycles", cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (width_us[i] !== 16'd1500) begin
        errors++;
        $display("[TB] FAIL reset_width[%0d]: got %0d required 1500", i, width_us[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b required 1", cmd_ready);
    end
    checks++;
    if (at_target !== 5'h1f) begin
      errors++;
      $display("[TB] FAIL reset_at_target: got %h required 1f", at_target);
    end
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err: got %b required 0", cmd_err);
    end
    rst_n = 1'b1;
    // Tick is high in cycle 15, so cmd_ready drops after the 16th edge.
    repeat (15) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL early_tick: cmd_ready=%b required 1 after 15 edges", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_tick: cmd_ready=%b required 0 after 16 edges", cmd_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_pass_len: cmd_ready=%b required 1 after 5 low cycles", cmd_ready);
    end
  endtask

  task automatic test_up_ramp();
    send_cmd(3'd0, 16'd2000);
    @(negedge clk);
    checks++;
    if (at_target[0] !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL up_new_target: at_target[0]=%b busy=%b required 0/1", at_target[0], busy);
    end
    for (int k = 1; k <= 50; k++) begin
      wait_pass();
      checks++;
      if (width_us[0] !== 16'(1500 + 10 * k)) begin
        errors++;
        $display("[TB] FAIL up_step[%0d]: width0=%0d required %0d", k, width_us[0], 1500 + 10 * k);
      end
      if (k == 49) begin
        checks++;
        if (at_target[0] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL up_not_yet: at_target[0]=%b required 0", at_target[0]);
        end
      end
    end
    checks++;
    if (at_target !== 5'h1f || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_done: at_target=%h busy=%b required 1f/0", at_target, busy);
    end
    for (int i = 1; i < NCH; i++) begin
      checks++;
      if (width_us[i] !== 16'd1500) begin
        errors++;
        $display("[TB] FAIL up_others[%0d]: got %0d required 1500", i, width_us[i]);
      end
    end
  endtask

  task automatic test_clamp();
    send_cmd(3'd1, 16'd2600);
    send_cmd(3'd2, 16'd400);
    send_cmd(3'd3, 16'd1504);
    for (int k = 1; k <= 51; k++) begin
      wait_pass();
      if (k == 1) begin
        checks++;
        if (width_us[1] !== 16'd1510 || width_us[2] !== 16'd1490 || width_us[3] !== 16'd1504) begin
          errors++;
          $display("[TB] FAIL clamp_first: w1=%0d w2=%0d w3=%0d required 1510/1490/1504",
                   width_us[1], width_us[2], width_us[3]);
        end
        checks++;
        if (at_target[3] !== 1'b1 || at_target[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL clamp_partial_at: at_target=%h required bit3=1 bit1=0", at_target);
        end
      end
      if (k == 49) begin
        checks++;
        if (width_us[2] !== 16'd1010) begin
          errors++;
          $display("[TB] FAIL clamp_low49: got %0d required 1010", width_us[2]);
        end
      end
      if (k == 50) begin
        checks++;
        if (width_us[2] !== 16'd1000 || width_us[1] !== 16'd2000) begin
          errors++;
          $display("[TB] FAIL clamp_50: w1=%0d w2=%0d required 2000/1000", width_us[1], width_us[2]);
        end
      end
    end
    checks++;
    if (width_us[1] !== 16'd2000 || width_us[2] !== 16'd1000) begin
      errors++;
      $display("[TB] FAIL clamp_hold: w1=%0d w2=%0d required 2000/1000", width_us[1], width_us[2]);
    end
    checks++;
    if (at_target !== 5'h1f || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_done: at_target=%h busy=%b required 1f/0", at_target, busy);
    end
  endtask

  task automatic test_bad_channel();
    logic [15:0] exp_w [NCH];
    exp_w = '{16'd2000, 16'd2000, 16'd1000, 16'd1504, 16'd1500};
    for (int b = 5; b <= 6; b++) begin
      cmd_valid    = 1'b1;
      cmd_ch       = 3'(b);
      cmd_width_us = 16'd1200;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (cmd_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bad_err_pulse[ch%0d]: got %b required 1", b, cmd_err);
      end
      @(negedge clk);
      checks++;
      if (cmd_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bad_err_width[ch%0d]: got %b required 0", b, cmd_err);
      end
    end
    wait_pass();
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (width_us[i] !== exp_w[i]) begin
        errors++;
        $display("[TB] FAIL bad_no_change[%0d]: got %0d required %0d", i, width_us[i], exp_w[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_handshake();
    int n;
    int low_cnt;
    n = 0;
    while (cmd_ready !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    // Hold a command across the whole pass.
    cmd_valid    = 1'b1;
    cmd_ch       = 3'd4;
    cmd_width_us = 16'd1600;
    low_cnt = (cmd_ready === 1'b0) ? 1 : 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (cmd_ready === 1'b0) low_cnt++;
      else break;
    end
    checks++;
    if (low_cnt != 5) begin
      errors++;
      $display("[TB] FAIL ready_low_cycles: got %0d required 5", low_cnt);
    end
    checks++;
    if (width_us[4] !== 16'd1500) begin
      errors++;
      $display("[TB] FAIL held_cmd_early: width4=%0d required 1500", width_us[4]);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (at_target[4] !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_cmd_accept: at_target[4]=%b cmd_err=%b required 0/0", at_target[4], cmd_err);
    end
    // Eight more falling edges places the drive in the tick cycle.
    repeat (8) @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_ch       = 3'd4;
    cmd_width_us = 16'd1400;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tick_same_cycle: cmd_ready=%b required 0", cmd_ready);
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (width_us[4] !== 16'd1490) begin
      errors++;
      $display("[TB] FAIL same_cycle_target: width4=%0d required 1490", width_us[4]);
    end
  endtask

  task automatic test_last_write();
    send_cmd(3'd4, 16'd1700);
    send_cmd(3'd4, 16'd1450);
    wait_pass();
    checks++;
    if (width_us[4] !== 16'd1480) begin
      errors++;
      $display("[TB] FAIL last_write_wins: width4=%0d required 1480", width_us[4]);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(3'd0, 16'd2000);
    repeat (23) wait_pass();
    checks++;
    if (width_us[0] !== 16'd1730) begin
      errors++;
      $display("[TB] FAIL mid_ramp_setup: width0=%0d required 1730", width_us[0]);
    end
    n = 0;
    while (cmd_ready !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_ramp_update: cmd_ready=%b required 0", cmd_ready);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (width_us[i] !== 16'd1500) begin
        errors++;
        $display("[TB] FAIL mid_reset_width[%0d]: got %0d required 1500", i, width_us[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || at_target !== 5'h1f) begin
      errors++;
      $display("[TB] FAIL mid_reset_flags: busy=%b ready=%b at_target=%h required 0/1/1f",
               busy, cmd_ready, at_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || width_us[0] !== 16'd1500 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_resume: ready=%b width0=%0d busy=%b required 1/1500/0",
               cmd_ready, width_us[0], busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_up_ramp();
    test_clamp();
    test_bad_channel();
    test_handshake();
    test_last_write();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
